// File: rtl/tone_meter_pkg.sv
// Shared types and helpers for the tone_meter receive-side frequency meter.
package tone_meter_pkg;

    localparam int NCO_ACC_W = 28;

    typedef enum logic {ARM, RUN} fsm_state_t;
    typedef enum logic {LO, HI} schmitt_state_t;

    // Magnitude of a signed sample; -32768 has no positive twin so it clips.
    function automatic logic [15:0] abs_sat(input logic signed [15:0] v);
        if (v == 16'sh8000)
            return 16'h7fff;
        else if (v[15])
            return 16'(-v);
        else
            return 16'(v);
    endfunction

endpackage

// File: rtl/tone_meter_schmitt_edge.sv
// Input register plus hysteresis comparator producing a rising-crossing pulse.
module schmitt_edge
    import tone_meter_pkg::*;
#(
    parameter int HYST = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [15:0] din,
    output logic signed [15:0] s,
    output logic               rise
);

    localparam logic signed [15:0] HI_TH = 16'(HYST);
    localparam logic signed [15:0] LO_TH = 16'(-HYST);

    schmitt_state_t state, state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s     <= '0;
            state <= LO;
        end else if (en) begin
            s     <= din;
            state <= state_next;
        end
    end

    // rise is combinational on s so the crossing lands one cycle after sampling.
    always_comb begin
        state_next = state;
        rise       = 1'b0;
        case (state)
            LO: if (s > HI_TH) begin
                state_next = HI;
                rise       = 1'b1;
            end
            HI: if (s < LO_TH) state_next = LO;
        endcase
    end

endmodule

// File: rtl/tone_meter.sv
// Gated-window tone frequency meter reporting NCO phase-increment units.
// Define TONE_METER_PEAK_EN to build the per-window peak magnitude tracker.
module tone_meter
    import tone_meter_pkg::*;
#(
    parameter int GATE_LOG2 = 20,
    parameter int HYST      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic signed [15:0]    din,
    output logic                  valid,
    output logic [GATE_LOG2-1:0]  edges,
    output logic [NCO_ACC_W-1:0]  freq,
    output logic [15:0]           peak,
    output logic                  locked
);

    localparam logic signed [15:0] ARM_TH = 16'(-HYST);

    logic signed [15:0]   s;
    logic                 rise;
    fsm_state_t           state, state_next;
    logic [GATE_LOG2-1:0] gate_cnt, edge_cnt, edge_sum;
    logic                 running, gate_wrap, count_rise;

    schmitt_edge #(.HYST(HYST)) u_schmitt (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (din),
        .s    (s),
        .rise (rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ARM;
        else      state <= state_next;
    end

    // Arming on a clearly negative sample guarantees the Schmitt state is LO.
    always_comb begin
        state_next = state;
        case (state)
            ARM: if (en && (s < ARM_TH)) state_next = RUN;
            RUN: state_next = RUN;
        endcase
    end

    always_comb begin
        running    = en && (state == RUN);
        gate_wrap  = running && (gate_cnt == '1);
        count_rise = running && rise;
        edge_sum   = edge_cnt;
        if (count_rise && (edge_cnt != '1))
            edge_sum = edge_cnt + GATE_LOG2'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (en) begin
            if (state == RUN) begin
                gate_cnt <= gate_cnt + GATE_LOG2'(1);
                edge_cnt <= gate_wrap ? '0 : edge_sum;
            end else begin
                gate_cnt <= '0;
                edge_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            edges  <= '0;
            freq   <= '0;
            locked <= 1'b0;
        end else begin
            valid <= gate_wrap;
            if (gate_wrap) begin
                edges <= edge_sum;
                freq  <= NCO_ACC_W'(edge_sum) << (NCO_ACC_W - GATE_LOG2);
            end
            if (count_rise) locked <= 1'b1;
        end
    end

`ifdef TONE_METER_PEAK_EN
    logic [15:0] abs_s, peak_acc, peak_sum;

    always_comb begin
        abs_s    = abs_sat(s);
        peak_sum = (abs_s > peak_acc) ? abs_s : peak_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_acc <= '0;
            peak     <= '0;
        end else begin
            if (running) peak_acc <= gate_wrap ? '0 : peak_sum;
            if (gate_wrap) peak <= peak_sum;
        end
    end
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_tone_meter.sv
// Scoreboard bench for tone_meter: stimulus queues expected windows, a monitor checks each valid.
module tb_tone_meter;

    localparam int GL = 10;
    localparam int HY = 256;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en  = 1'b0;
    logic signed [15:0] din = '0;
    logic               valid;
    logic [GL-1:0]      edges;
    logic [27:0]        freq;
    logic [15:0]        peak;
    logic               locked;

    typedef struct {
        int edges;
        int freq;
        int peak;
        int gap;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_cyc = 0;

    tone_meter #(.GATE_LOG2(GL), .HYST(HY)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .din    (din),
        .valid  (valid),
        .edges  (edges),
        .freq   (freq),
        .peak   (peak),
        .locked (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int pk(input int v);
`ifdef TONE_METER_PEAK_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic signed [15:0] sq(input int i, input int period, input int amp);
        return ((i % period) < (period / 2)) ? 16'(-amp) : 16'(amp);
    endfunction

    task automatic pushExpect(input int e, input int f, input int p, input int g);
        exp_t x;
        x.edges = e;
        x.freq  = f;
        x.peak  = p;
        x.gap   = g;
        q.push_back(x);
    endtask

    task automatic applyStimulus(input logic signed [15:0] v, input logic e);
        din = v;
        en  = e;
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst = 1'b0;
        en  = 1'b1;
        din = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drainCheck(input string name);
        repeat (4) @(negedge clk);
        checkOutput({name, "_pending_windows"}, q.size(), 0);
    endtask

    // Monitor: every valid pulse must match the oldest queued window.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got valid=1 edges=%0d expected no valid", edges);
            end else begin
                e = q.pop_front();
                checkOutput("edges", int'(edges), e.edges);
                checkOutput("freq", int'(freq), e.freq);
                checkOutput("peak", int'(peak), e.peak);
                if (e.gap != 0)
                    checkOutput("valid_gap", int'(cyc - last_cyc), e.gap);
            end
            last_cyc = cyc;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int phase;

        // Reset state
        resetDut();
        rst = 1'b0;
        #1;
        checkOutput("rst_valid", int'(valid), 0);
        checkOutput("rst_edges", int'(edges), 0);
        checkOutput("rst_freq", int'(freq), 0);
        checkOutput("rst_peak", int'(peak), 0);
        checkOutput("rst_locked", int'(locked), 0);

        // 64-cycle square, +/-1000
        resetDut();
        pushExpect(16, 4194304, pk(1000), 0);
        repeat (3) pushExpect(16, 4194304, pk(1000), 1024);
        for (int i = 0; i < 5000; i++) applyStimulus(sq(i, 64, 1000), 1'b1);
        checkOutput("t1_locked", int'(locked), 1);
        drainCheck("t1");

        // DC +5000 must not arm; then 32-cycle square, +/-5000
        resetDut();
        for (int i = 0; i < 1500; i++) applyStimulus(16'sd5000, 1'b1);
        checkOutput("t2_dc_locked", int'(locked), 0);
        pushExpect(32, 8388608, pk(5000), 0);
        pushExpect(32, 8388608, pk(5000), 1024);
        for (int i = 0; i < 2100; i++) applyStimulus(sq(i, 32, 5000), 1'b1);
        checkOutput("t2_locked", int'(locked), 1);
        drainCheck("t2");

        // Arm with one low sample, then +/-200 stays inside hysteresis
        resetDut();
        pushExpect(0, 0, pk(200), 0);
        pushExpect(0, 0, pk(200), 1024);
        for (int i = 0; i < 2100; i++)
            applyStimulus((i == 0) ? -16'sd1000 : sq(i, 64, 200), 1'b1);
        checkOutput("t3_locked", int'(locked), 0);
        drainCheck("t3");

        // Single full-scale negative sample in the first window
        resetDut();
        pushExpect(0, 0, pk(32767), 0);
        pushExpect(0, 0, 0, 1024);
        for (int i = 0; i < 2100; i++)
            applyStimulus((i == 0) ? -16'sd1000 : ((i == 500) ? 16'sh8000 : 16'sd0), 1'b1);
        drainCheck("t4");

        // en low for 500 cycles inside the second window; waveform pauses too
        resetDut();
        pushExpect(16, 4194304, pk(1000), 0);
        pushExpect(16, 4194304, pk(1000), 1524);
        pushExpect(16, 4194304, pk(1000), 1024);
        phase = 0;
        for (int i = 0; i < 3700; i++) begin
            if (i >= 1500 && i < 2000) begin
                applyStimulus(din, 1'b0);
            end else begin
                applyStimulus(sq(phase, 64, 1000), 1'b1);
                phase++;
            end
        end
        drainCheck("t5");

        // Reset 300 cycles into the second window, then re-measure
        resetDut();
        pushExpect(16, 4194304, pk(1000), 0);
        for (int i = 0; i < 1325; i++) applyStimulus(sq(i, 64, 1000), 1'b1);
        checkOutput("t6_locked_before", int'(locked), 1);
        rst = 1'b0;
        #1;
        checkOutput("t6_valid", int'(valid), 0);
        checkOutput("t6_edges", int'(edges), 0);
        checkOutput("t6_freq", int'(freq), 0);
        checkOutput("t6_peak", int'(peak), 0);
        checkOutput("t6_locked", int'(locked), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pushExpect(16, 4194304, pk(1000), 0);
        pushExpect(16, 4194304, pk(1000), 1024);
        for (int i = 0; i < 2100; i++) applyStimulus(sq(i, 64, 1000), 1'b1);
        drainCheck("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
